// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit slice. It adds one nibble per clock and
// registers the carry between nibbles; operands and result use valid/ready handshakes.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [IDXW+1:0]  base_c;
  logic [3:0]       add_a_c, add_b_c, add_sum_c;
  logic             add_cout_c;

  // Bit offset of the nibble currently being added.
  assign base_c  = {idx_q, 2'b00};
  assign add_a_c = a_q[base_c +: 4];
  assign add_b_c = b_q[base_c +: 4];

  adder_4bit u_adder (
    .a    (add_a_c),
    .b    (add_b_c),
    .cin  (carry_q),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base_c +: 4] = add_sum_c;
        carry_d            = add_cout_c;
        idx_d              = idx_q + IDXW'(1);
        if (idx_q == IDXW'(N - 1)) begin
          cout_d      = add_cout_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder against a plain-arithmetic model.

module tb_nibble_serial_adder;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  // One full transaction with out_ready held high; operands are scrambled after acceptance.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input string tag);
    logic [WIDTH:0] exp;
    int acc;
    exp = model(ta, tb_v, tc);
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
    wait_ready(tag);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(tag);
    chk({tag, "_lat"}, 32'(cyc - acc), 32'(N));
    chk({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
    @(posedge clk); #1;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] hs;
    logic             hc;
    logic [WIDTH-1:0] bb_a [3];
    logic [WIDTH-1:0] bb_b [3];
    int acc, prev_acc;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    run_txn(16'h1234, 16'h4321, 1'b0, "d1");
    run_txn(16'hFFFF, 16'h0001, 1'b0, "d2");
    run_txn(16'hFFFF, 16'h0000, 1'b1, "d3");
    run_txn(16'h8000, 16'h8000, 1'b1, "d4");
    run_txn(16'h0F0F, 16'h00F1, 1'b0, "d5");

    // Backpressure: result held, new operands ignored until the handshake.
    out_ready = 1'b0;
    exp = model(16'hABCD, 16'h1357, 1'b1);
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1;
    wait_ready("bp");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("bp");
    hs = sum; hc = cout;
    chk("bp_sum", 32'(hs), 32'(exp[WIDTH-1:0]));
    chk("bp_cout", 32'(hc), 32'(exp[WIDTH]));
    in_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum), 32'(hs));
      chk("bp_hold_cout", 32'(cout), 32'(hc));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_new_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_valid("bp_new");
    chk("bp_new_sum", 32'(sum), 32'h0303);
    chk("bp_new_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN.
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    wait_ready("ar");
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_sum", 32'(sum), 32'd0);
    chk("ar_cout", 32'(cout), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_txn(16'h0001, 16'h0002, 1'b0, "ar_post");

    // Back-to-back with in_valid held high.
    bb_a[0] = 16'h1111; bb_b[0] = 16'h2222;
    bb_a[1] = 16'hA5A5; bb_b[1] = 16'h5A5A;
    bb_a[2] = 16'hFFFF; bb_b[2] = 16'hFFFF;
    in_valid = 1'b1; cin = 1'b0; a = bb_a[0]; b = bb_b[0];
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ready("bb");
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) chk("bb_period", 32'(acc - prev_acc), 32'(N + 2));
      prev_acc = acc;
      if (i < 2) begin a = bb_a[i+1]; b = bb_b[i+1]; end
      else in_valid = 1'b0;
      exp = model(bb_a[i], bb_b[i], 1'b0);
      wait_valid("bb");
      chk("bb_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
      chk("bb_cout", 32'(cout), 32'(exp[WIDTH]));
    end
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++)
      run_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
